shape_processor_mc: RTL and testbench

//   Multi-channel successor of the single-SFR shape processor. Holds NUM_CH
//   per-channel control SFRs (shape + operation) with WARL-style legality

---
 rtl/shape_processor_mc.sv | 199 +++++++++++++++++++
 tb/tb_shape_processor_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shape_processor_mc.sv
`default_nettype none
// ============================================================================
// Module      : shape_processor_mc
// Description : Multi-channel shape/operation control SFR block with a shared
//               execution engine. Each channel holds a 2-bit one-hot shape and
//               a 5-bit operation code. Writes that would produce an illegal
//               setting are dropped. A start request runs one channel for
//               OP_LATENCY cycles and then pulses done.
// Ports       :
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   write      in   write strobe for SFR[addr]
//   addr       in   channel select for write/read
//   write_data in   [17:16]=shape, [4:0]=operation
//   read       in   read strobe for SFR[addr]
//   read_data  out  {14'b0, shape, 11'b0, operation}, registered
//   start      in   execute request
//   start_ch   in   channel to execute
//   busy       out  engine running
//   done       out  single-cycle pulse at end of operation
//   done_ch    out  channel of the finished operation, valid with done
//   err_clr    in   clears sticky error
//   error      out  sticky rejection flag
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module shape_processor_mc #(
  parameter  int NUM_CH     = 4,
  parameter  int OP_LATENCY = 3,
  localparam int AW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          write,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   write_data,
  input  logic          read,
  output logic [31:0]   read_data,
  input  logic          start,
  input  logic [AW-1:0] start_ch,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] done_ch,
  input  logic          err_clr,
  output logic          error
);

  localparam int            CW       = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(OP_LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic op_legal(input logic [4:0] o);
    case (o[4:3])
      2'b00, 2'b10: op_legal = (o[2:1] == 2'b00);
      2'b01:        op_legal = (o[2:0] == 3'b000);
      default:      op_legal = 1'b0;
    endcase
  endfunction

  // Class-specific operations must match the shape they are paired with.
  function automatic logic combo_legal(input logic [4:0] o, input logic [1:0] s);
    combo_legal = (o[4:3] == 2'b00) || (o[4:3] == s);
  endfunction

  logic [1:0]        shape_q [NUM_CH];
  logic [4:0]        op_q    [NUM_CH];
  logic [NUM_CH-1:0] upd_full;
  logic [NUM_CH-1:0] upd_op;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     active_ch_q;
  logic [2**AW-1:0]  ch_valid;
  logic [31:0]       rd_word;

  logic [1:0] new_shape;
  logic [4:0] new_op;
  logic       new_op_ok;
  logic       new_shape_onehot;
  logic       start_ok;
  logic       start_reject;
  logic       write_reject;
  logic       unused_wdata;

  assign new_shape        = write_data[17:16];
  assign new_op           = write_data[4:0];
  assign new_op_ok        = op_legal(new_op);
  assign new_shape_onehot = (new_shape == 2'b01) || (new_shape == 2'b10);
  assign unused_wdata     = ^{write_data[31:18], write_data[15:5]};

  // Address space is rounded up to a power of two; mark codes that map to a channel.
  generate
    for (genvar i = 0; i < 2**AW; i++) begin : g_valid
      assign ch_valid[i] = (i < NUM_CH) ? 1'b1 : 1'b0;
    end
  endgenerate

  // Per-channel write decode. A channel that is executing is locked against
  // writes; a shape field of 00 means "keep the current shape".
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic hit;
      assign hit = write && (addr == AW'(i)) && !(busy && (active_ch_q == AW'(i)));
      assign upd_full[i] = hit && new_shape_onehot && new_op_ok &&
                           combo_legal(new_op, new_shape);
      assign upd_op[i]   = hit && (new_shape == 2'b00) && new_op_ok &&
                           combo_legal(new_op, shape_q[i]);
    end
  endgenerate

  // Any write not accepted by some channel (bad address, locked, illegal) is a rejection.
  assign write_reject = write && !(|upd_full || |upd_op);
  assign start_ok     = start && ch_valid[start_ch] && (state_q != S_RUN);
  assign start_reject = start && !start_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shape_q[i] <= 2'b01;
        op_q[i]    <= 5'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (upd_full[i]) begin
          shape_q[i] <= new_shape;
          op_q[i]    <= new_op;
        end else if (upd_op[i]) begin
          op_q[i]    <= new_op;
        end
      end
    end
  end

  always_comb begin
    rd_word = 32'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == AW'(i)) rd_word = {14'b0, shape_q[i], 11'b0, op_q[i]};
    end
  end

  // Registered read sees the SFR before any same-cycle write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    read_data <= 32'b0;
    else if (read) read_data <= rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            error <= 1'b0;
    else if (write_reject || start_reject) error <= 1'b1;
    else if (err_clr)                      error <= 1'b0;
  end

  // Engine: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Engine: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start_ok ? S_RUN : S_IDLE;
      S_RUN:          if (cnt_q == '0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Engine: channel snapshot and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      active_ch_q <= '0;
    end else if (start_ok) begin
      cnt_q       <= CNT_INIT;
      active_ch_q <= start_ch;
    end else if ((state_q == S_RUN) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Engine: outputs
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    done_ch = '0;
    case (state_q)
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        done    = 1'b1;
        done_ch = active_ch_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_shape_processor_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_shape_processor_mc
// Description : Directed self-checking bench for shape_processor_mc. Expected
//               read words and finishing channels are queued when stimulus is
//               applied and compared when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shape_processor_mc;

  localparam int NUM_CH     = 4;
  localparam int OP_LATENCY = 3;
  localparam int AW         = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   write_data = '0;
  logic          read = 1'b0;
  logic [31:0]   read_data;
  logic          start = 1'b0;
  logic [AW-1:0] start_ch = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] done_ch;
  logic          err_clr = 1'b0;
  logic          error;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd_q[$];
  logic [31:0] done_q[$];

  shape_processor_mc #(.NUM_CH(NUM_CH), .OP_LATENCY(OP_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .addr(addr), .write_data(write_data),
    .read(read), .read_data(read_data), .start(start), .start_ch(start_ch),
    .busy(busy), .done(done), .done_ch(done_ch), .err_clr(err_clr), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; every done pulse is matched against the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done) begin
      if (done_q.size() == 0) check("done_unexpected", {31'b0, done}, 32'd0);
      else                    check("done_ch", {30'b0, done_ch}, done_q.pop_front());
    end
  endtask

  task automatic clear_inputs();
    write = 1'b0; read = 1'b0; start = 1'b0; err_clr = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp);
    addr = a; read = 1'b1;
    rd_q.push_back(exp);
    tick();
    read = 1'b0;
    check("read_data", read_data, rd_q.pop_front());
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    addr = a; write_data = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("error_cleared", {31'b0, error}, 32'd0);
  endtask

  task automatic wait_done(input int max_cycles);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_timeout", {31'b0, got}, 32'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_done_ch", {30'b0, done_ch}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int c = 0; c < NUM_CH; c++) rd(AW'(c), 32'h0001_0000);
    check("error_after_reset", {31'b0, error}, 32'd0);

    // Full update, op-only update, then a class mismatch on ch2
    wr(2, 32'h0002_0010);
    rd(2, 32'h0002_0010);
    wr(2, 32'h0000_0011);
    rd(2, 32'h0002_0011);
    check("error_legal_writes", {31'b0, error}, 32'd0);
    wr(2, 32'h0000_0008);
    check("error_combo_reject", {31'b0, error}, 32'd1);
    rd(2, 32'h0002_0011);
    clr_err();

    // Read data holds while read is low
    addr = 0; tick();
    check("read_hold", read_data, 32'h0002_0011);

    // Read and write of the same channel in one cycle returns the old value
    addr = 2; write_data = 32'h0001_0000; write = 1'b1; read = 1'b1;
    rd_q.push_back(32'h0002_0011);
    tick();
    clear_inputs();
    check("read_during_write", read_data, rd_q.pop_front());
    rd(2, 32'h0001_0000);

    // Illegal shape and illegal op on ch1
    wr(1, 32'h0003_0000);
    check("error_bad_shape", {31'b0, error}, 32'd1);
    rd(1, 32'h0001_0000);
    clr_err();
    wr(1, 32'h0001_0018);
    check("error_bad_op", {31'b0, error}, 32'd1);
    rd(1, 32'h0001_0000);
    clr_err();
    wr(1, 32'h0001_0008);
    rd(1, 32'h0001_0008);

    // Set wins over a simultaneous clear
    err_clr = 1'b1; addr = 1; write_data = 32'h0003_0000; write = 1'b1;
    tick();
    clear_inputs();
    check("error_set_wins", {31'b0, error}, 32'd1);
    clr_err();

    // Exact-latency run of ch3
    start = 1'b1; start_ch = 3; done_q.push_back(32'd3);
    tick();
    clear_inputs();
    check("run_t1_busy", {31'b0, busy}, 32'd1);
    check("run_t1_done", {31'b0, done}, 32'd0);
    tick();
    check("run_t2_busy", {31'b0, busy}, 32'd1);
    start = 1'b1; start_ch = 0;
    write = 1'b1; addr = 3; write_data = 32'h0002_0010;
    tick();
    clear_inputs();
    check("run_t3_busy", {31'b0, busy}, 32'd1);
    check("run_t3_done", {31'b0, done}, 32'd0);
    check("error_start_in_run", {31'b0, error}, 32'd1);
    write = 1'b1; addr = 0; write_data = 32'h0001_0001; err_clr = 1'b1;
    tick();
    clear_inputs();
    check("run_t4_done", {31'b0, done}, 32'd1);
    check("run_t4_busy", {31'b0, busy}, 32'd0);
    check("error_after_clear", {31'b0, error}, 32'd0);
    tick();
    check("done_single_pulse", {31'b0, done}, 32'd0);
    rd(3, 32'h0001_0000);
    rd(0, 32'h0001_0001);

    // Start and write same channel, then back-to-back start in DONE
    start = 1'b1; start_ch = 0; done_q.push_back(32'd0);
    write = 1'b1; addr = 0; write_data = 32'h0002_0010;
    tick();
    clear_inputs();
    check("start_write_busy", {31'b0, busy}, 32'd1);
    check("start_write_error", {31'b0, error}, 32'd0);
    tick();
    tick();
    tick();
    check("b2b_done", {31'b0, done}, 32'd1);
    start = 1'b1; start_ch = 1; done_q.push_back(32'd1);
    tick();
    clear_inputs();
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_error", {31'b0, error}, 32'd0);
    rd(0, 32'h0002_0010);
    wait_done(10);
    tick();
    check("b2b_done_cleared", {31'b0, done}, 32'd0);

    // Reset in the middle of a run
    start = 1'b1; start_ch = 1;
    tick();
    clear_inputs();
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy", {31'b0, busy}, 32'd0);
    tick();
    tick();
    check("reset_no_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    rd(1, 32'h0001_0000);
    rd(0, 32'h0001_0000);
    rd(2, 32'h0001_0000);
    check("post_reset_error", {31'b0, error}, 32'd0);
    check("done_queue_empty", done_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
